// File: rtl/sprite_engine_pkg.sv
// rtl/sprite_engine_pkg.sv - shared state encoding and default geometry for the sprite engine
package sprite_engine_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_SPR_W   = 16;
    localparam int DEF_SPR_H   = 16;

    localparam logic [1:0] ST_ALIVE     = 2'd0;
    localparam logic [1:0] ST_EXPLODING = 2'd1;
    localparam logic [1:0] ST_HIDDEN    = 2'd2;

endpackage

// File: rtl/sprite_engine_bitmap_rom.sv
// rtl/sprite_engine_bitmap_rom.sv - combinational bitmap ROM: two ship frames (repeated) plus one explosion frame
module sprite_bitmap_rom
    import sprite_engine_pkg::*;
#(
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int FRAMES = 2,
    parameter int ROW_W  = $clog2(SPR_H)
) (
    input  logic [2:0]       i_frame,
    input  logic [ROW_W-1:0] i_row,
    output logic [SPR_W-1:0] o_row_data
);

    logic [3:0]  w_row4;
    logic [15:0] w_bits;

    assign w_row4 = 4'(i_row);

    function automatic logic [15:0] ship_row(input logic [3:0] r, input logic variant);
        logic [15:0] v;
        case (r)
            4'd0, 4'd1:   v = 16'h0180;
            4'd2, 4'd3:   v = 16'h03C0;
            4'd4, 4'd5:   v = 16'h07E0;
            4'd6:         v = 16'h0FF0;
            4'd7:         v = 16'h1FF8;
            4'd8:         v = 16'h3FFC;
            4'd9:         v = 16'h7FFE;
            4'd10, 4'd11: v = 16'hFFFF;
            4'd12:        v = 16'hE7E7;
            4'd13:        v = variant ? 16'h6666 : 16'hC3C3;
            4'd14:        v = variant ? 16'h2424 : 16'h8181;
            default:      v = variant ? 16'h1818 : 16'hF248;
        endcase
        return v;
    endfunction

    // Frame index FRAMES selects the explosion; normal frames alternate the two ship variants
    always_comb begin
        w_bits = 16'h0000;
        if (i_frame == 3'(FRAMES)) begin
            w_bits = w_row4[0] ? 16'h9249 : 16'h2492;
        end else begin
            w_bits = ship_row(w_row4, i_frame[0]);
        end
    end

    assign o_row_data = SPR_W'(w_bits);

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - single sprite with animation, explosion FSM and 2-stage pixel pipeline
module sprite_engine
    import sprite_engine_pkg::*;
#(
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int FRAMES     = 2,
    parameter int SCALE_LOG2 = 0,
    parameter int ANIM_DIV   = 8,
    parameter int EXPL_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] i_pix_x,
    input  logic [COORD_W-1:0] i_pix_y,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  logic               i_frame_tick,
    input  logic               i_anim_en,
    input  logic               i_mirror,
    input  logic               i_hit,
    input  logic               i_respawn,
    output logic               o_pix_on,
    output logic               o_alive,
    output logic               o_expl_done,
    output logic [1:0]         o_frame_idx
);

    localparam int ROW_W = $clog2(SPR_H);
    localparam int COL_W = $clog2(SPR_W);
    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int EXP_W = $clog2(EXPL_TICKS + 1);

    logic [1:0]       r_state;
    logic [1:0]       r_frame_idx;
    logic [DIV_W-1:0] r_div;
    logic [EXP_W-1:0] r_expl;
    logic             r_expl_done;

    logic             r_s1_in_box;
    logic [ROW_W-1:0] r_s1_row;
    logic [COL_W-1:0] r_s1_col;
    logic [2:0]       r_s1_frame;
    logic             r_pix_on;

    logic [COORD_W:0]   w_x_end;
    logic [COORD_W:0]   w_y_end;
    logic               w_in_box;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [COL_W-1:0]   w_col;
    logic [COL_W-1:0]   w_col_eff;
    logic [ROW_W-1:0]   w_row;
    logic [SPR_W-1:0]   w_rom_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ALIVE;
            r_frame_idx <= 2'd0;
            r_div       <= '0;
            r_expl      <= '0;
            r_expl_done <= 1'b0;
        end else begin
            r_expl_done <= 1'b0;
            case (r_state)
                ST_ALIVE: begin
                    // A hit swallows a coincident frame_tick
                    if (i_hit) begin
                        r_state     <= ST_EXPLODING;
                        r_expl      <= EXP_W'(EXPL_TICKS);
                        r_frame_idx <= 2'd0;
                    end else if (i_frame_tick && i_anim_en) begin
                        if (r_div == DIV_W'(ANIM_DIV - 1)) begin
                            r_div       <= '0;
                            r_frame_idx <= (r_frame_idx == 2'(FRAMES - 1)) ? 2'd0 : r_frame_idx + 2'd1;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                ST_EXPLODING: begin
                    if (i_frame_tick) begin
                        r_expl <= r_expl - 1'b1;
                        if (r_expl == EXP_W'(1)) begin
                            r_state     <= ST_HIDDEN;
                            r_expl_done <= 1'b1;
                        end
                    end
                end
                ST_HIDDEN: begin
                    if (i_respawn) begin
                        r_state     <= ST_ALIVE;
                        r_frame_idx <= 2'd0;
                        r_div       <= '0;
                    end
                end
                default: r_state <= ST_ALIVE;
            endcase
        end
    end

    // Box end computed one bit wider so a sprite at the right/bottom edge clips instead of wrapping
    assign w_x_end  = {1'b0, i_pos_x} + (COORD_W+1)'(BOX_W);
    assign w_y_end  = {1'b0, i_pos_y} + (COORD_W+1)'(BOX_H);
    assign w_in_box = (i_pix_x >= i_pos_x) && ({1'b0, i_pix_x} < w_x_end) &&
                      (i_pix_y >= i_pos_y) && ({1'b0, i_pix_y} < w_y_end);

    assign w_dx      = i_pix_x - i_pos_x;
    assign w_dy      = i_pix_y - i_pos_y;
    assign w_col     = COL_W'(w_dx >> SCALE_LOG2);
    assign w_row     = ROW_W'(w_dy >> SCALE_LOG2);
    assign w_col_eff = i_mirror ? (COL_W'(SPR_W - 1) - w_col) : w_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_in_box <= 1'b0;
            r_s1_row    <= '0;
            r_s1_col    <= '0;
            r_s1_frame  <= 3'd0;
            r_pix_on    <= 1'b0;
        end else begin
            r_s1_in_box <= w_in_box && (r_state != ST_HIDDEN);
            r_s1_row    <= w_row;
            r_s1_col    <= w_col_eff;
            r_s1_frame  <= (r_state == ST_EXPLODING) ? 3'(FRAMES) : {1'b0, r_frame_idx};
            r_pix_on    <= r_s1_in_box & w_rom_row[COL_W'(SPR_W - 1) - r_s1_col];
        end
    end

    sprite_bitmap_rom #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .FRAMES (FRAMES),
        .ROW_W  (ROW_W)
    ) u_rom (
        .i_frame    (r_s1_frame),
        .i_row      (r_s1_row),
        .o_row_data (w_rom_row)
    );

    assign o_pix_on    = r_pix_on;
    assign o_alive     = (r_state == ST_ALIVE);
    assign o_expl_done = r_expl_done;
    assign o_frame_idx = r_frame_idx;

endmodule
